// File: rtl/aes_block_serializer_if.sv
// aes_block_serializer_if
//   Bundles the block-side and byte-side signals of the AES block serializer.
//
//   Handshake semantics (both sides):
//     block side: blockIn is taken at a rising edge where blockValid && blockReady.
//                 blockValid is a one-cycle strobe. It is not held until accepted:
//                 a strobe with blockReady low is lost and flagged on overflow.
//     byte side : a byte moves at a rising edge where byteValid && byteReady.
//                 While byteValid is high and byteReady is low, byteOut and
//                 byteLast hold stable.
//
//   Signals:
//     blockIn     [0:127]  AES state word, state byte k at bits [8k:8k+7]
//     blockValid           one-cycle strobe that blockIn is valid
//     blockReady           a block offered this cycle will be accepted
//     byteOut     [7:0]    current output byte
//     byteValid            byteOut is valid
//     byteReady            downstream accepts byteOut this cycle
//     byteLast             high with byte 15 of a block
//     busy                 a block is active or pending
//     overflow             sticky drop flag
//     clearOvf             synchronous clear of overflow
//     dbg_state            current FSM state (0 = IDLE, 1 = SEND)
//
//   Modports:
//     master : the environment (core and downstream sink)
//     slave  : the serializer
interface aes_block_serializer_if;
  logic [0:127] blockIn;
  logic         blockValid;
  logic         blockReady;
  logic [7:0]   byteOut;
  logic         byteValid;
  logic         byteReady;
  logic         byteLast;
  logic         busy;
  logic         overflow;
  logic         clearOvf;
  logic [0:0]   dbg_state;

  modport master (
    output blockIn, blockValid, byteReady, clearOvf,
    input  blockReady, byteOut, byteValid, byteLast, busy, overflow, dbg_state
  );

  modport slave (
    input  blockIn, blockValid, byteReady, clearOvf,
    output blockReady, byteOut, byteValid, byteLast, busy, overflow, dbg_state
  );
endinterface

// File: rtl/aes_block_serializer.sv
// aes_block_serializer
//   Takes a 128-bit column-major AES state word when the core strobes it.
//   Optionally undoes the state-matrix transpose, then streams the 16 bytes
//   out one per valid/ready handshake. One more block can wait in a pending
//   slot, so a result that arrives while a block is still streaming is
//   kept and follows with no bubble.
//
//   Parameters:
//     TRANSPOSE  1 = output byte n is state byte 4*(n mod 4) + (n div 4)
//                0 = output byte n is state byte n
//     BYTE_W     byte width, fixed at 8
//
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous active-low reset
//     bus   aes_block_serializer_if.slave (the signal list is in the interface file)
module aes_block_serializer #(
  parameter bit TRANSPOSE = 1'b1,
  parameter int BYTE_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  aes_block_serializer_if.slave   bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [3:0]   index_q, index_d;
  logic [0:127] active_q, active_d;
  logic [0:127] pend_q, pend_d;
  logic         pend_valid_q, pend_valid_d;
  logic         ovf_q, ovf_d;

  logic         block_ready;
  logic         accept;
  logic         xfer;
  logic         last_xfer;
  logic [3:0]   sel;
  logic [6:0]   base;

  always_comb begin
    block_ready = !pend_valid_q;
    accept      = bus.blockValid && block_ready;
    xfer        = (state_q == ST_SEND) && bus.byteReady;
    last_xfer   = xfer && (index_q == 4'd15);
    // Swapping the two index halves picks state byte 4*(n mod 4) + (n div 4).
    sel         = TRANSPOSE ? {index_q[1:0], index_q[3:2]} : index_q;
    base        = {sel, 3'b000};
  end

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    active_d     = active_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          active_d = bus.blockIn;
          index_d  = 4'd0;
          state_d  = ST_SEND;
        end
      end
      default: begin
        if (last_xfer) begin
          if (pend_valid_q) begin
            // Promote the waiting block so byte 0 follows byte 15 directly.
            active_d     = pend_q;
            pend_valid_d = 1'b0;
            index_d      = 4'd0;
          end else if (accept) begin
            active_d = bus.blockIn;
            index_d  = 4'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (xfer) begin
            index_d = index_q + 4'd1;
          end
          if (accept) begin
            pend_d       = bus.blockIn;
            pend_valid_d = 1'b1;
          end
        end
      end
    endcase
  end

  // A rejected strobe sets the flag. Set takes priority over clear.
  always_comb begin
    ovf_d = ovf_q;
    if (bus.blockValid && !block_ready) begin
      ovf_d = 1'b1;
    end else if (bus.clearOvf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      index_q      <= 4'd0;
      active_q     <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  // All outputs come from registered state only. byteOut is forced to zero
  // outside SEND so it reads 0x00 in reset and idle.
  assign bus.blockReady = block_ready;
  assign bus.byteValid  = (state_q == ST_SEND);
  assign bus.byteOut    = (state_q == ST_SEND) ? active_q[base +: BYTE_W] : '0;
  assign bus.byteLast   = (state_q == ST_SEND) && (index_q == 4'd15);
  assign bus.busy       = (state_q == ST_SEND) || pend_valid_q;
  assign bus.overflow   = ovf_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_aes_block_serializer.sv
// tb_aes_block_serializer
//   Directed bench for aes_block_serializer (TRANSPOSE=1). Inputs are driven
//   on the falling edge and outputs are sampled there, half a cycle away from
//   the active edge. Every check is an immediate assertion against a
//   hand-written expected value.
module tb_aes_block_serializer;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  aes_block_serializer_if bus ();

  aes_block_serializer #(.TRANSPOSE(1'b1), .BYTE_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Consume one byte with byteReady high, checking it against the expected value.
  task automatic take(input string tag, input logic [7:0] e, input logic l);
    bus.byteReady = 1'b1;
    check({tag, "_valid"}, {31'd0, bus.byteValid}, 32'd1);
    check({tag, "_byte"},  {24'd0, bus.byteOut},   {24'd0, e});
    check({tag, "_last"},  {31'd0, bus.byteLast},  {31'd0, l});
    @(negedge clk);
  endtask

  task automatic offer(input logic [127:0] blk);
    bus.blockIn    = blk;
    bus.blockValid = 1'b1;
  endtask

  function automatic logic [7:0] byte_of(input logic [127:0] msg, input int n);
    return msg[127-8*n -: 8];
  endfunction

  logic [127:0] blk_a, exp_a, blk_b, exp_b, blk_msg, exp_msg;
  logic [3:0]   pat;
  int           n;
  int           cycles;
  int           seen;

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst            = 1'b0;
    bus.blockIn    = '0;
    bus.blockValid = 1'b0;
    bus.byteReady  = 1'b1;
    bus.clearOvf   = 1'b0;

    // Counting block and its transposed stream
    blk_a   = 128'h000102030405060708090A0B0C0D0E0F;
    exp_a   = 128'h0004080C0105090D02060A0E03070B0F;
    blk_b   = 128'h101112131415161718191A1B1C1D1E1F;
    exp_b   = 128'h1014181C1115191D12161A1E13171B1F;
    // Packer output for "This is a test!!"
    blk_msg = 128'h54206173686920746973742173206521;
    exp_msg = "This is a test!!";

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // reset state
    check("rst_valid", {31'd0, bus.byteValid},  32'd0);
    check("rst_byte",  {24'd0, bus.byteOut},    32'd0);
    check("rst_last",  {31'd0, bus.byteLast},   32'd0);
    check("rst_busy",  {31'd0, bus.busy},       32'd0);
    check("rst_ovf",   {31'd0, bus.overflow},   32'd0);
    check("rst_ready", {31'd0, bus.blockReady}, 32'd1);
    check("rst_state", {31'd0, bus.dbg_state},  32'd0);

    // 1: transpose order, latency 1, return to IDLE
    offer(blk_a);
    @(negedge clk);
    bus.blockValid = 1'b0;
    check("t1_busy", {31'd0, bus.busy}, 32'd1);
    for (int i = 0; i < 16; i++) take("t1", byte_of(exp_a, i), (i == 15));
    check("t1_idle_valid", {31'd0, bus.byteValid}, 32'd0);
    check("t1_idle_busy",  {31'd0, bus.busy},      32'd0);
    check("t1_idle_state", {31'd0, bus.dbg_state}, 32'd0);

    // 2: round trip of the packed message
    @(negedge clk);
    offer(blk_msg);
    @(negedge clk);
    bus.blockValid = 1'b0;
    for (int i = 0; i < 16; i++) take("t2", byte_of(exp_msg, i), (i == 15));
    check("t2_idle_valid", {31'd0, bus.byteValid}, 32'd0);

    // 3: backpressure 1,0,0,1 -> 16 transfers + 16 stalls = 32 cycles
    offer(blk_b);
    @(negedge clk);
    bus.blockValid = 1'b0;
    pat    = 4'b1001;
    n      = 0;
    cycles = 0;
    while (n < 16 && cycles < 64) begin
      bus.byteReady = pat[3 - (cycles % 4)];
      check("t3_valid", {31'd0, bus.byteValid}, 32'd1);
      check("t3_byte",  {24'd0, bus.byteOut},   {24'd0, byte_of(exp_b, n)});
      check("t3_last",  {31'd0, bus.byteLast},  {31'd0, (n == 15)});
      if (bus.byteReady) n++;
      cycles++;
      @(negedge clk);
    end
    bus.byteReady = 1'b1;
    check("t3_count",  n,      32'd16);
    check("t3_cycles", cycles, 32'd32);
    check("t3_idle",   {31'd0, bus.byteValid}, 32'd0);

    // 4: back-to-back, B strobed mid-stream of A
    offer(blk_a);
    @(negedge clk);
    bus.blockValid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.blockValid = 1'b0;
      if (i == 6) begin
        check("t4_ready_low", {31'd0, bus.blockReady}, 32'd0);
        check("t4_busy",      {31'd0, bus.busy},       32'd1);
      end
      if (i == 5) offer(blk_b);
      take("t4a", byte_of(exp_a, i), (i == 15));
    end
    bus.blockValid = 1'b0;
    check("t4_ready_back", {31'd0, bus.blockReady}, 32'd1);
    for (int i = 0; i < 16; i++) take("t4b", byte_of(exp_b, i), (i == 15));
    check("t4_end_busy",  {31'd0, bus.busy},      32'd0);
    check("t4_end_valid", {31'd0, bus.byteValid}, 32'd0);

    // 5: overflow, set-wins-over-clear, clear alone, reject on last byte
    offer(blk_a);
    @(negedge clk);
    bus.blockValid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.blockValid = 1'b0;
      bus.clearOvf   = 1'b0;
      if (i == 4) check("t5_ovf_pre",  {31'd0, bus.overflow}, 32'd0);
      if (i == 5) check("t5_ovf_set",  {31'd0, bus.overflow}, 32'd1);
      if (i == 7) check("t5_ovf_hold", {31'd0, bus.overflow}, 32'd1);
      if (i == 9) check("t5_ovf_clr",  {31'd0, bus.overflow}, 32'd0);
      if (i == 2)  offer(blk_b);
      if (i == 4)  offer({16{8'hCC}});
      if (i == 6)  begin offer({16{8'hDD}}); bus.clearOvf = 1'b1; end
      if (i == 8)  bus.clearOvf = 1'b1;
      if (i == 15) offer({16{8'hEE}});
      take("t5a", byte_of(exp_a, i), (i == 15));
    end
    bus.blockValid = 1'b0;
    bus.clearOvf   = 1'b0;
    check("t5_ovf_last",   {31'd0, bus.overflow},   32'd1);
    check("t5_ready_prom", {31'd0, bus.blockReady}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      bus.clearOvf = (i == 0);
      if (i == 1) check("t5_ovf_clr2", {31'd0, bus.overflow}, 32'd0);
      take("t5b", byte_of(exp_b, i), (i == 15));
    end
    bus.clearOvf = 1'b0;
    check("t5_end_busy",  {31'd0, bus.busy},      32'd0);
    check("t5_end_valid", {31'd0, bus.byteValid}, 32'd0);

    // 6: reset at byte 7 of A with B pending and overflow set
    offer(blk_a);
    @(negedge clk);
    bus.blockValid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.blockValid = 1'b0;
      if (i == 2) offer(blk_b);
      if (i == 4) offer({16{8'hCC}});
      take("t6a", byte_of(exp_a, i), 1'b0);
    end
    bus.blockValid = 1'b0;
    check("t6_pre_ovf",  {31'd0, bus.overflow}, 32'd1);
    check("t6_pre_busy", {31'd0, bus.busy},     32'd1);
    rst = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, bus.byteValid}, 32'd0);
    check("t6_rst_byte",  {24'd0, bus.byteOut},   32'd0);
    check("t6_rst_last",  {31'd0, bus.byteLast},  32'd0);
    check("t6_rst_busy",  {31'd0, bus.busy},      32'd0);
    check("t6_rst_ovf",   {31'd0, bus.overflow},  32'd0);
    check("t6_rst_state", {31'd0, bus.dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.byteReady = 1'b1;
    @(negedge clk);
    check("t6_rel_ready", {31'd0, bus.blockReady}, 32'd1);
    check("t6_rel_valid", {31'd0, bus.byteValid},  32'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.byteValid) seen++;
      @(negedge clk);
    end
    check("t6_no_bytes", seen, 32'd0);
    check("t6_rel_busy", {31'd0, bus.busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
